softmax_normalize: RTL and testbench
====================================

# softmax_normalize

Softmax accumulate-and-normalize stage that brackets the Newton-Raphson reciprocal unit. It accepts a stream of N_ELEM unsigned Q6.26 exponentials and buffers them while accumulating their sum. It presents the sum to the reciprocal unit, waits for the Q0.16 reciprocal, then streams out N_ELEM Q0.16 probabilities (exp × 1/sum).

## Interface
- N_ELEM, 32: elements per softmax vector (power of two, ≥2)
- IN_WIDTH, 32: exp and sum width, unsigned Q6.26
- BIT_WIDTH, 16: reciprocal and probability width, unsigned Q0.16
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_exp_valid  in  1  exp element valid
- i_exp  in  IN_WIDTH  exp element, Q6.26
- o_exp_ready  out  1  block can accept an exp element
- o_sum_valid  out  1  one-cycle pulse, o_sum valid; drives reciprocal unit i_valid
- o_sum  out  IN_WIDTH  saturated sum of the vector, Q6.26; drives reciprocal unit i_sum
- i_recip_valid  in  1  reciprocal valid (reciprocal unit o_valid)
- i_recip  in  BIT_WIDTH  1/sum, Q0.16
- o_prob_valid  out  1  probability valid
- o_prob  out  BIT_WIDTH  probability, Q0.16
- o_prob_last  out  1  marks element N_ELEM-1 of a vector
- o_busy  out  1  high in S_WAIT and S_NORM

## Operation
- FSM states: S_ACCUM, S_WAIT, S_NORM. Reset state is S_ACCUM.
- S_ACCUM:
  - o_exp_ready=1; a handshake is i_exp_valid & o_exp_ready.
  - Each handshake writes buf[cnt]=i_exp, updates acc=sat(acc+i_exp), and increments cnt.
  - acc saturates at 2^IN_WIDTH-1.
  - On the handshake with cnt=N_ELEM-1: register o_sum=sat(acc+i_exp), pulse o_sum_valid, clear acc and cnt, go to S_WAIT.
- S_WAIT:
  - o_exp_ready=0; i_exp_valid is ignored (no accept, no buffer write).
  - On i_recip_valid: latch recip=i_recip, set idx=0, go to S_NORM.
  - i_recip_valid in any other state is ignored.
- S_NORM, one element per cycle:
  - p = buf[idx] × recip (IN_WIDTH+BIT_WIDTH bits, Q6.42).
  - r = (p + 2^25) >> 26 (round half up).
  - o_prob = r > 2^BIT_WIDTH-1 ? 2^BIT_WIDTH-1 : r (saturate).
  - All three outputs are registered.
  - At idx=N_ELEM-1: assert o_prob_last with that element, go to S_ACCUM.
- No output backpressure: the consumer must accept one probability per cycle.
- Reset values: o_exp_ready=0 while i_rst is high, 1 in the first cycle after release. o_sum_valid=0, o_sum=0, o_prob_valid=0, o_prob=0, o_prob_last=0, o_busy=0. acc, cnt, idx and recip are 0. buf contents are don't-care.
- Reset mid-vector (any state): the partial vector is discarded, the FSM returns to S_ACCUM, and no stale o_prob or o_sum_valid appears afterwards.

## Timing
- The last exp handshake at cycle T gives o_sum_valid=1 at T+1 (registered).
- i_recip_valid sampled at cycle R in S_WAIT gives:
  - o_prob_valid high for cycles R+2 through R+N_ELEM+1 inclusive;
  - element k at cycle R+2+k;
  - o_prob_last at cycle R+N_ELEM+1.
- The FSM re-enters S_ACCUM at R+N_ELEM+1, so o_exp_ready is high that cycle.
  - A new element 0 may be accepted while the last probability is on the output; buf[N_ELEM-1] was already read.
- Latency from sum to recip is set by the reciprocal unit (ITERATIONS+1 cycles). This block waits indefinitely in S_WAIT.
- Throughput: one vector per 2·N_ELEM + reciprocal latency + 2 cycles, at most.

## Structure
- Package softmax_pkg holds:
  - Q6.26 and Q0.16 format localparams (frac bits 26/16, ONE_Q6_26 = 2^26);
  - the state enum type;
  - the rounding constant.
- Sub-module softmax_norm_mul: combinational multiply, round and saturate, so it can be shared or pipelined later.
- buf is an N_ELEM×IN_WIDTH register array with combinational read by idx.

## Test plan
- **Uniform vector:** 32 × 0x0400_0000 (1.0) → o_sum=0x8000_0000 at T+1; drive i_recip=0x0800 → 32 outputs of 0x0800, o_prob_last only on the 32nd.
- **One-hot:** exp[0]=0x0400_0000, others 0 → o_sum=0x0400_0000; drive i_recip=0xFFFF → prob[0]=0xFFFF, prob[1..31]=0.
- **Rounding and saturation:**
  - exp=0x0200_0000 with recip=0x0001 gives prob=0x0001 (2^25+2^25 >> 26).
  - exp=0x0800_0000 with recip=0xFFFF gives 0xFFFF (saturated from 0x1FFFE).
- **Protocol:** hold i_exp_valid=1 through S_WAIT/S_NORM → no accepts and buffer unchanged. Pulse i_recip_valid during S_ACCUM → ignored. Drive i_recip_valid 7 cycles after o_sum_valid → outputs begin exactly 2 cycles later.
- **Gapped input:** toggle i_exp_valid randomly → exactly 32 accepts, and o_sum equals the reference sum.
- **Reset mid-S_NORM:** assert i_rst at element 10 → all outputs 0 immediately; a full fresh vector afterwards produces correct sum and probabilities with no stale valids.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared formats, FSM encoding and rounding constant for the softmax
// accumulate-and-normalize stage.
package softmax_pkg;

  // Fixed-point formats: exponentials and sums are Q6.26, reciprocal and
  // probabilities are Q0.16.
  localparam int Q6_26_FRAC = 26;
  localparam int Q0_16_FRAC = 16;
  localparam int unsigned ONE_Q6_26 = 32'h0400_0000;

  // Half an LSB of the final Q0.16 result, expressed in the Q6.42 product.
  // Adding it before the shift gives round-half-up.
  localparam int unsigned ROUND_Q6_26 = ONE_Q6_26 >> 1;

  typedef enum logic [1:0] {
    S_ACCUM = 2'd0,
    S_WAIT  = 2'd1,
    S_NORM  = 2'd2
  } state_t;

endpackage

// File: rtl/softmax_norm_mul.sv
// Combinational Q6.26 x Q0.16 multiply, round-half-up and saturate to
// Q0.16. Kept separate so it can be shared or pipelined later.
module softmax_norm_mul
  import softmax_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int BIT_WIDTH = 16
) (
  input  logic [IN_WIDTH-1:0]  exp_val,
  input  logic [BIT_WIDTH-1:0] recip,
  output logic [BIT_WIDTH-1:0] prob
);

  localparam int PROD_W    = IN_WIDTH + BIT_WIDTH;
  localparam int PW1       = PROD_W + 1;
  // Product is Q6.42; drop down to Q0.16 by discarding 42-16 fraction bits.
  localparam int PROD_FRAC = Q6_26_FRAC + Q0_16_FRAC;
  localparam int SHIFT     = PROD_FRAC - Q0_16_FRAC;

  logic [PROD_W-1:0] prod;
  logic [PW1-1:0]    prod_rnd;
  logic [PW1-1:0]    shifted;
  logic [PW1-1:0]    max_prob;

  // Multiply, add half an output LSB, shift, then clamp to the Q0.16 range.
  always_comb begin
    prod     = PROD_W'(exp_val) * PROD_W'(recip);
    prod_rnd = {1'b0, prod} + PW1'(ROUND_Q6_26);
    shifted  = prod_rnd >> SHIFT;
    max_prob = PW1'({BIT_WIDTH{1'b1}});
    if (shifted > max_prob) begin
      prob = '1;
    end else begin
      prob = shifted[BIT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/softmax_normalize.sv
// Softmax accumulate-and-normalize stage: buffers a vector of Q6.26
// exponentials while summing them, hands the sum to the reciprocal unit,
// then streams out exp * (1/sum) as Q0.16 probabilities.
//
// Handshake: an exp element transfers on a rising edge where
// i_exp_valid && o_exp_ready are both high; data is only sampled then and
// o_exp_ready does not depend on i_exp_valid. o_sum_valid, i_recip_valid
// and o_prob_valid are single-cycle qualifiers with no back-pressure: the
// receiver must take the value in the cycle its valid is high.
module softmax_normalize
  import softmax_pkg::*;
#(
  parameter int N_ELEM    = 32,
  parameter int IN_WIDTH  = 32,
  parameter int BIT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_exp_valid,
  input  logic [IN_WIDTH-1:0]  i_exp,
  output logic                 o_exp_ready,
  output logic                 o_sum_valid,
  output logic [IN_WIDTH-1:0]  o_sum,
  input  logic                 i_recip_valid,
  input  logic [BIT_WIDTH-1:0] i_recip,
  output logic                 o_prob_valid,
  output logic [BIT_WIDTH-1:0] o_prob,
  output logic                 o_prob_last,
  output logic                 o_busy,
  output logic [1:0]           o_state
);

  localparam int              CNT_W = $clog2(N_ELEM);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ELEM - 1);

  state_t               state;
  state_t               next_state;
  logic [IN_WIDTH-1:0]  acc;
  logic [IN_WIDTH:0]    acc_wide;
  logic [IN_WIDTH-1:0]  acc_sum;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     idx;
  logic [BIT_WIDTH-1:0] recip;
  logic [BIT_WIDTH-1:0] prob_next;
  logic [IN_WIDTH-1:0]  exp_buf [N_ELEM];
  logic                 accept;
  logic                 last_in;
  logic                 last_out;
  logic                 recip_take;

  assign accept   = i_exp_valid & o_exp_ready;
  assign last_in  = (cnt == LAST);
  assign last_out = (idx == LAST);
  assign o_state  = state;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_ACCUM;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: fill the vector, wait for the reciprocal, emit N_ELEM results.
  always_comb begin
    next_state = state;
    case (state)
      S_ACCUM: if (accept && last_in) next_state = S_WAIT;
      S_WAIT:  if (i_recip_valid)     next_state = S_NORM;
      S_NORM:  if (last_out)          next_state = S_ACCUM;
      default:                        next_state = S_ACCUM;
    endcase
  end

  // FSM outputs; ready is forced low while reset is held.
  always_comb begin
    o_exp_ready = (state == S_ACCUM) && !i_rst;
    o_busy      = (state == S_WAIT) || (state == S_NORM);
    recip_take  = (state == S_WAIT) && i_recip_valid;
  end

  // Saturating running sum including the element currently offered.
  always_comb begin
    acc_wide = {1'b0, acc} + {1'b0, i_exp};
    acc_sum  = acc_wide[IN_WIDTH] ? '1 : acc_wide[IN_WIDTH-1:0];
  end

  // Element buffer: written on accepted handshakes only, no reset needed.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      exp_buf[cnt] <= i_exp;
    end
  end

  softmax_norm_mul #(
    .IN_WIDTH  (IN_WIDTH),
    .BIT_WIDTH (BIT_WIDTH)
  ) u_mul (
    .exp_val (exp_buf[idx]),
    .recip   (recip),
    .prob    (prob_next)
  );

  // Accumulation, sum hand-off, reciprocal latch and registered probabilities.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc          <= '0;
      cnt          <= '0;
      idx          <= '0;
      recip        <= '0;
      o_sum        <= '0;
      o_sum_valid  <= 1'b0;
      o_prob       <= '0;
      o_prob_valid <= 1'b0;
      o_prob_last  <= 1'b0;
    end else begin
      o_sum_valid  <= 1'b0;
      o_prob_valid <= 1'b0;
      o_prob_last  <= 1'b0;
      if (accept) begin
        if (last_in) begin
          o_sum       <= acc_sum;
          o_sum_valid <= 1'b1;
          acc         <= '0;
          cnt         <= '0;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
        end
      end
      if (recip_take) begin
        recip <= i_recip;
        idx   <= '0;
      end
      if (state == S_NORM) begin
        o_prob       <= prob_next;
        o_prob_valid <= 1'b1;
        o_prob_last  <= last_out;
        idx          <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_softmax_normalize.sv
// Directed bench for softmax_normalize: hand-computed vectors, immediate
// assertions at each comparison, expected probabilities held in a queue.
module tb_softmax_normalize;

  localparam int N_ELEM    = 32;
  localparam int IN_WIDTH  = 32;
  localparam int BIT_WIDTH = 16;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b1;
  logic                 i_exp_valid = 1'b0;
  logic [IN_WIDTH-1:0]  i_exp = '0;
  logic                 o_exp_ready;
  logic                 o_sum_valid;
  logic [IN_WIDTH-1:0]  o_sum;
  logic                 i_recip_valid = 1'b0;
  logic [BIT_WIDTH-1:0] i_recip = '0;
  logic                 o_prob_valid;
  logic [BIT_WIDTH-1:0] o_prob;
  logic                 o_prob_last;
  logic                 o_busy;
  logic [1:0]           o_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [IN_WIDTH-1:0]  vec [N_ELEM];
  logic [BIT_WIDTH-1:0] exp_q [$];

  softmax_normalize #(
    .N_ELEM    (N_ELEM),
    .IN_WIDTH  (IN_WIDTH),
    .BIT_WIDTH (BIT_WIDTH)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_exp_valid   (i_exp_valid),
    .i_exp         (i_exp),
    .o_exp_ready   (o_exp_ready),
    .o_sum_valid   (o_sum_valid),
    .o_sum         (o_sum),
    .i_recip_valid (i_recip_valid),
    .i_recip       (i_recip),
    .o_prob_valid  (o_prob_valid),
    .o_prob        (o_prob),
    .o_prob_last   (o_prob_last),
    .o_busy        (o_busy),
    .o_state       (o_state)
  );

  // Clock and watchdog.
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},      o_exp_ready,  1'b0);
    check({tag, "_sum_valid"},  o_sum_valid,  1'b0);
    check({tag, "_sum"},        o_sum,        '0);
    check({tag, "_prob_valid"}, o_prob_valid, 1'b0);
    check({tag, "_prob"},       o_prob,       '0);
    check({tag, "_prob_last"},  o_prob_last,  1'b0);
    check({tag, "_busy"},       o_busy,       1'b0);
  endtask

  // Offer vec[] to the block (optionally with random gaps) and check the sum.
  task automatic send_vector(input bit gapped, input logic [IN_WIDTH-1:0] exp_sum);
    int  n_acc = 0;
    int  guard = 0;
    bit  hs;
    while (n_acc < N_ELEM && guard < 2000) begin
      i_exp       = vec[n_acc];
      i_exp_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      hs          = i_exp_valid && o_exp_ready;
      tick();
      guard++;
      if (hs) n_acc++;
    end
    i_exp_valid = 1'b0;
    check("accept_count", n_acc, N_ELEM);
    check("sum_valid", o_sum_valid, 1'b1);
    check("sum", o_sum, exp_sum);
    check("busy_wait", o_busy, 1'b1);
    check("ready_wait", o_exp_ready, 1'b0);
    check("state_wait", o_state, 2'd1);
  endtask

  // Wait `delay` cycles after the sum pulse, present the reciprocal and
  // score the stream. Stops after element stop_at when stop_at >= 0.
  task automatic run_norm(input int delay, input logic [BIT_WIDTH-1:0] recip,
                          input int stop_at, input bit hold_exp);
    logic [BIT_WIDTH-1:0] expv;
    if (hold_exp) begin
      i_exp_valid = 1'b1;
      i_exp       = 32'hDEAD_BEEF;
    end
    for (int d = 0; d < delay; d++) begin
      tick();
      check("sum_pulse_one_cycle", o_sum_valid, 1'b0);
      check("ready_in_wait", o_exp_ready, 1'b0);
      check("no_prob_in_wait", o_prob_valid, 1'b0);
    end
    i_recip_valid = 1'b1;
    i_recip       = recip;
    tick();
    i_recip_valid = 1'b0;
    i_recip       = 16'hA5A5;
    check("prob_latency_r1", o_prob_valid, 1'b0);
    check("ready_in_norm", o_exp_ready, 1'b0);
    tick();
    for (int k = 0; k < N_ELEM; k++) begin
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check($sformatf("prob_valid[%0d]", k), o_prob_valid, 1'b1);
      check($sformatf("prob[%0d]", k), o_prob, expv);
      check($sformatf("prob_last[%0d]", k), o_prob_last, (k == N_ELEM - 1));
      if (k == N_ELEM - 1) begin
        check("ready_on_last", o_exp_ready, 1'b1);
        i_exp_valid = 1'b0;
      end
      if (k == stop_at) return;
      tick();
    end
    check("prob_valid_after", o_prob_valid, 1'b0);
    check("prob_last_after", o_prob_last, 1'b0);
    check("busy_after", o_busy, 1'b0);
  endtask

  task automatic pulse_reset(input string tag);
    i_rst = 1'b1;
    #1;
    check_idle_outputs(tag);
    tick();
    tick();
    i_rst = 1'b0;
    #1;
    check({tag, "_ready_release"}, o_exp_ready, 1'b1);
    check({tag, "_state_release"}, o_state, 2'd0);
  endtask

  // Directed stimulus.
  initial begin
    // Reset state.
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset_state", o_state, 2'd0);
    i_rst = 1'b0;
    #1;
    check("ready_after_release", o_exp_ready, 1'b1);
    tick();

    // Stray reciprocal during accumulate is ignored.
    i_recip_valid = 1'b1;
    i_recip       = 16'h1234;
    tick();
    i_recip_valid = 1'b0;
    check("stray_recip_busy", o_busy, 1'b0);
    check("stray_recip_ready", o_exp_ready, 1'b1);
    tick();
    check("stray_recip_no_prob", o_prob_valid, 1'b0);

    // Uniform: 32 x 1.0 -> sum 32.0, recip 1/32 -> 0x0800 each.
    for (int i = 0; i < N_ELEM; i++) begin
      vec[i] = 32'h0400_0000;
      exp_q.push_back(16'h0800);
    end
    send_vector(1'b0, 32'h8000_0000);
    run_norm(0, 16'h0800, -1, 1'b0);

    // One-hot with exp input held valid through WAIT/NORM and a 7-cycle
    // reciprocal delay; buffer must stay untouched.
    for (int i = 0; i < N_ELEM; i++) begin
      vec[i] = (i == 0) ? 32'h0400_0000 : 32'h0;
      exp_q.push_back((i == 0) ? 16'hFFFF : 16'h0000);
    end
    send_vector(1'b0, 32'h0400_0000);
    run_norm(7, 16'hFFFF, -1, 1'b1);

    // Rounding with recip=1 and a saturating sum:
    // 0x0200_0000 -> 1 (half up), 0x01FF_FFFF -> 0, 0x0600_0000 -> 2,
    // 0xF000_0000 -> 0x3C.
    for (int i = 0; i < N_ELEM; i++) begin
      case (i % 4)
        0: begin vec[i] = 32'h0200_0000; exp_q.push_back(16'h0001); end
        1: begin vec[i] = 32'h01FF_FFFF; exp_q.push_back(16'h0000); end
        2: begin vec[i] = 32'h0600_0000; exp_q.push_back(16'h0002); end
        default: begin vec[i] = 32'hF000_0000; exp_q.push_back(16'h003C); end
      endcase
    end
    send_vector(1'b0, 32'hFFFF_FFFF);
    run_norm(1, 16'h0001, -1, 1'b0);

    // Output saturation with recip=0xFFFF:
    // 2.0 -> 0x1FFFE clamps to 0xFFFF, 1.0 -> 0xFFFF, 0.5 -> 0x8000, 0 -> 0.
    // Sum = 8 * 3.5 = 28.0 = 0x7000_0000.
    for (int i = 0; i < N_ELEM; i++) begin
      case (i % 4)
        0: begin vec[i] = 32'h0800_0000; exp_q.push_back(16'hFFFF); end
        1: begin vec[i] = 32'h0400_0000; exp_q.push_back(16'hFFFF); end
        2: begin vec[i] = 32'h0200_0000; exp_q.push_back(16'h8000); end
        default: begin vec[i] = 32'h0000_0000; exp_q.push_back(16'h0000); end
      endcase
    end
    send_vector(1'b0, 32'h7000_0000);
    run_norm(2, 16'hFFFF, -1, 1'b0);

    // Gapped input: exp[i] = (i+1)/64, sum = 528/64 = 0x2100_0000;
    // recip 0x0100 gives prob[i] = 4*(i+1).
    for (int i = 0; i < N_ELEM; i++) begin
      vec[i] = 32'h0010_0000 * (i + 1);
      exp_q.push_back(16'(4 * (i + 1)));
    end
    send_vector(1'b1, 32'h2100_0000);
    run_norm(3, 16'h0100, -1, 1'b0);

    // Reset mid-normalize at element 10.
    for (int i = 0; i < N_ELEM; i++) begin
      vec[i] = 32'h0400_0000;
      exp_q.push_back(16'h0800);
    end
    send_vector(1'b0, 32'h8000_0000);
    run_norm(2, 16'h0800, 10, 1'b0);
    exp_q.delete();
    pulse_reset("rst_norm");
    for (int c = 0; c < 3; c++) begin
      tick();
      check("no_stale_prob", o_prob_valid, 1'b0);
      check("no_stale_sum", o_sum_valid, 1'b0);
    end

    // Partial vector then reset: the discarded elements must not leak into
    // the next sum (5 x max would saturate it).
    i_exp_valid = 1'b1;
    i_exp       = 32'hFFFF_FFFF;
    repeat (5) tick();
    i_exp_valid = 1'b0;
    pulse_reset("rst_accum");
    tick();
    for (int i = 0; i < N_ELEM; i++) begin
      case (i % 4)
        0: begin vec[i] = 32'h0800_0000; exp_q.push_back(16'hFFFF); end
        1: begin vec[i] = 32'h0400_0000; exp_q.push_back(16'hFFFF); end
        2: begin vec[i] = 32'h0200_0000; exp_q.push_back(16'h8000); end
        default: begin vec[i] = 32'h0000_0000; exp_q.push_back(16'h0000); end
      endcase
    end
    send_vector(1'b0, 32'h7000_0000);
    run_norm(0, 16'hFFFF, -1, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
